// File: rtl/ff_mode_pkg.sv
// Shared mode encodings for the multi-mode flip-flop bank; no latency.
// Pure definitions, no flow control.
package ff_mode_pkg;

  typedef enum logic [1:0] {
    MODE_D  = 2'b00,
    MODE_T  = 2'b01,
    MODE_JK = 2'b10,
    MODE_SR = 2'b11
  } ff_mode_e;

endpackage

// File: rtl/ff_next_bit.sv
// Per-bit next-state logic for D/T/JK/SR behaviour; combinational, zero latency.
// No flow control; illegal flags an SR bit with S=R=1, which then holds.
module ff_next_bit
  import ff_mode_pkg::*;
(
  input  ff_mode_e i_mode,
  input  logic     i_j,
  input  logic     i_k,
  input  logic     i_q,
  output logic     o_q_next,
  output logic     o_illegal
);

  always_comb begin
    o_q_next  = i_q;
    o_illegal = 1'b0;
    case (i_mode)
      MODE_D:  o_q_next = i_j;
      MODE_T:  o_q_next = i_q ^ i_j;
      MODE_JK: begin
        case ({i_j, i_k})
          2'b01:   o_q_next = 1'b0;
          2'b10:   o_q_next = 1'b1;
          2'b11:   o_q_next = ~i_q;
          default: o_q_next = i_q;
        endcase
      end
      MODE_SR: begin
        case ({i_j, i_k})
          2'b01:   o_q_next = 1'b0;
          2'b10:   o_q_next = 1'b1;
          2'b11:   o_illegal = 1'b1;
          default: o_q_next = i_q;
        endcase
      end
      default: o_q_next = i_q;
    endcase
  end

endmodule

// File: rtl/multi_mode_ff_bank.sv
// Bank of WIDTH flip-flops with runtime-selectable D/T/JK/SR behaviour; 1-cycle update latency.
// No backpressure: en gates updates, clr clears, sticky err and saturating change counter.
module multi_mode_ff_bank
  import ff_mode_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] J,
  input  logic [WIDTH-1:0] K,
  input  logic             err_clr,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qb,
  output logic             err,
  output logic [CNT_W-1:0] chg_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] r_q;
  logic             r_err;
  logic [CNT_W-1:0] r_chg_cnt;

  ff_mode_e         w_mode;
  logic [WIDTH-1:0] w_bit_next;
  logic [WIDTH-1:0] w_bit_illegal;
  logic [WIDTH-1:0] w_q_next;
  logic             w_err_set;
  logic             w_changed;

  assign w_mode = ff_mode_e'(mode);

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    ff_next_bit u_next (
      .i_mode   (w_mode),
      .i_j      (J[gi]),
      .i_k      (K[gi]),
      .i_q      (r_q[gi]),
      .o_q_next (w_bit_next[gi]),
      .o_illegal(w_bit_illegal[gi])
    );
  end

  // clr beats en; en=0 holds the bank.
  always_comb begin
    w_q_next = r_q;
    if (clr) begin
      w_q_next = '0;
    end else if (en) begin
      w_q_next = w_bit_next;
    end
  end

  assign w_err_set = en && !clr && (w_mode == MODE_SR) && (|w_bit_illegal);
  assign w_changed = (w_q_next != r_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_q       <= '0;
      r_err     <= 1'b0;
      r_chg_cnt <= '0;
    end else begin
      r_q <= w_q_next;
      // A coincident set outranks err_clr so no illegal event is lost.
      if (w_err_set) begin
        r_err <= 1'b1;
      end else if (err_clr) begin
        r_err <= 1'b0;
      end
      if (w_changed && (r_chg_cnt != CNT_MAX)) begin
        r_chg_cnt <= r_chg_cnt + 1'b1;
      end
    end
  end

  assign Q       = r_q;
  assign Qb      = ~r_q;
  assign err     = r_err;
  assign chg_cnt = r_chg_cnt;

endmodule

// File: tb/tb_multi_mode_ff_bank.sv
// Directed checks of the multi-mode flip-flop bank with hand-computed expectations.
// Second instance uses a 2-bit counter to exercise saturation.
module tb_multi_mode_ff_bank;

  logic       clk;
  logic       rst;
  logic       rst2;
  logic       en;
  logic       clr;
  logic [1:0] mode;
  logic [7:0] J;
  logic [7:0] K;
  logic       err_clr;

  logic [7:0]  Q, Qb;
  logic        err;
  logic [15:0] chg_cnt;

  logic [7:0] Q2, Qb2;
  logic       err2;
  logic [1:0] chg_cnt2;

  int n_tests;
  int n_fail;

  multi_mode_ff_bank #(.WIDTH(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .mode(mode), .J(J), .K(K),
    .err_clr(err_clr), .Q(Q), .Qb(Qb), .err(err), .chg_cnt(chg_cnt)
  );

  multi_mode_ff_bank #(.WIDTH(8), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst2), .en(en), .clr(clr), .mode(mode), .J(J), .K(K),
    .err_clr(err_clr), .Q(Q2), .Qb(Qb2), .err(err2), .chg_cnt(chg_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp_v);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; rst2 = 1'b0;
    en = 1'b1; clr = 1'b0; mode = 2'b00; J = 8'hFF; K = 8'h00; err_clr = 1'b0;
    #2;
    n_tests++;
    if (Q !== 8'h00) begin n_fail++; $display("FAIL reset_q: got %h expected 00", Q); end
    n_tests++;
    if (Qb !== 8'hFF) begin n_fail++; $display("FAIL reset_qb: got %h expected ff", Qb); end
    n_tests++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", err); end
    n_tests++;
    if (chg_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d expected 0", chg_cnt); end
    tick();
    n_tests++;
    if (Q !== 8'h00) begin n_fail++; $display("FAIL reset_held_edge: got %h expected 00", Q); end
    en = 1'b0;
    rst = 1'b1;
    tick();
    n_tests++;
    if (Q !== 8'h00 || chg_cnt !== 16'd0) begin
      n_fail++; $display("FAIL reset_release: got Q=%h cnt=%0d expected 00/0", Q, chg_cnt);
    end
  endtask

  task automatic test_d_t();
    en = 1'b1; mode = 2'b00; J = 8'hA5;
    tick();
    n_tests++;
    if (Q !== 8'hA5) begin n_fail++; $display("FAIL d_mode: got %h expected a5", Q); end
    mode = 2'b01; J = 8'h0F;
    tick();
    n_tests++;
    if (Q !== 8'hAA) begin n_fail++; $display("FAIL t_mode: got %h expected aa", Q); end
    n_tests++;
    if (Qb !== 8'h55) begin n_fail++; $display("FAIL t_qb: got %h expected 55", Qb); end
    n_tests++;
    if (chg_cnt !== 16'd2) begin n_fail++; $display("FAIL dt_cnt: got %0d expected 2", chg_cnt); end
  endtask

  task automatic test_jk();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    n_tests++;
    if (Q !== 8'h00) begin n_fail++; $display("FAIL jk_preclear: got %h expected 00", Q); end
    mode = 2'b10; J = 8'hFF; K = 8'hFF;
    tick();
    n_tests++;
    if (Q !== 8'hFF) begin n_fail++; $display("FAIL jk_toggle1: got %h expected ff", Q); end
    tick();
    n_tests++;
    if (Q !== 8'h00) begin n_fail++; $display("FAIL jk_toggle2: got %h expected 00", Q); end
    J = 8'h0F; K = 8'hF0;
    tick();
    n_tests++;
    if (Q !== 8'h0F) begin n_fail++; $display("FAIL jk_set_reset: got %h expected 0f", Q); end
    n_tests++;
    if (chg_cnt !== 16'd6) begin n_fail++; $display("FAIL jk_cnt: got %0d expected 6", chg_cnt); end
  endtask

  task automatic test_sr_illegal();
    mode = 2'b00; J = 8'h3C; K = 8'h00;
    tick();
    mode = 2'b11; J = 8'h01; K = 8'h01; err_clr = 1'b1;
    tick();
    n_tests++;
    if (Q !== 8'h3C) begin n_fail++; $display("FAIL sr_illegal_hold: got %h expected 3c", Q); end
    n_tests++;
    if (err !== 1'b1) begin n_fail++; $display("FAIL sr_err_set_wins: got %b expected 1", err); end
    n_tests++;
    if (chg_cnt !== 16'd7) begin n_fail++; $display("FAIL sr_illegal_cnt: got %0d expected 7", chg_cnt); end
    J = 8'h00; K = 8'h00;
    tick();
    err_clr = 1'b0;
    n_tests++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL sr_err_clear: got %b expected 0", err); end
    J = 8'hC0; K = 8'h0C;
    tick();
    n_tests++;
    if (Q !== 8'hF0) begin n_fail++; $display("FAIL sr_set_reset: got %h expected f0", Q); end
    n_tests++;
    if (err !== 1'b0 || chg_cnt !== 16'd8) begin
      n_fail++; $display("FAIL sr_legal_state: got err=%b cnt=%0d expected 0/8", err, chg_cnt);
    end
  endtask

  task automatic test_hold_priority();
    en = 1'b0; mode = 2'b00; J = 8'hFF;
    tick();
    n_tests++;
    if (Q !== 8'hF0 || chg_cnt !== 16'd8) begin
      n_fail++; $display("FAIL en_hold: got Q=%h cnt=%0d expected f0/8", Q, chg_cnt);
    end
    en = 1'b1; J = 8'h55;
    tick();
    n_tests++;
    if (Q !== 8'h55) begin n_fail++; $display("FAIL load_55: got %h expected 55", Q); end
    en = 1'b0; clr = 1'b1;
    tick();
    n_tests++;
    if (Q !== 8'h00 || chg_cnt !== 16'd10) begin
      n_fail++; $display("FAIL clr_no_en: got Q=%h cnt=%0d expected 00/10", Q, chg_cnt);
    end
    en = 1'b1; mode = 2'b11; J = 8'hFF; K = 8'hFF;
    tick();
    n_tests++;
    if (err !== 1'b0 || Q !== 8'h00 || chg_cnt !== 16'd10) begin
      n_fail++; $display("FAIL clr_over_sr: got err=%b Q=%h cnt=%0d expected 0/00/10", err, Q, chg_cnt);
    end
    clr = 1'b0; K = 8'h00;
  endtask

  task automatic test_saturation();
    logic [1:0] exp_cnt [5];
    logic [7:0] exp_q;
    exp_cnt[0] = 2'd1; exp_cnt[1] = 2'd2; exp_cnt[2] = 2'd3; exp_cnt[3] = 2'd3; exp_cnt[4] = 2'd3;
    en = 1'b0; clr = 1'b0; mode = 2'b01; J = 8'h01; K = 8'h00; err_clr = 1'b0;
    rst2 = 1'b1;
    tick();
    en = 1'b1;
    exp_q = 8'h00;
    for (int i = 0; i < 5; i++) begin
      tick();
      exp_q = exp_q ^ 8'h01;
      n_tests++;
      if (chg_cnt2 !== exp_cnt[i] || Q2 !== exp_q) begin
        n_fail++;
        $display("FAIL sat_step%0d: got cnt=%0d Q=%h expected %0d/%h", i, chg_cnt2, Q2, exp_cnt[i], exp_q);
      end
    end
    #2;
    rst2 = 1'b0;
    #1;
    n_tests++;
    if (Q2 !== 8'h00 || chg_cnt2 !== 2'd0 || Qb2 !== 8'hFF) begin
      n_fail++; $display("FAIL sat_async_rst: got Q=%h cnt=%0d Qb=%h expected 00/0/ff", Q2, chg_cnt2, Qb2);
    end
    tick();
    n_tests++;
    if (Q2 !== 8'h00 || chg_cnt2 !== 2'd0) begin
      n_fail++; $display("FAIL sat_rst_held: got Q=%h cnt=%0d expected 00/0", Q2, chg_cnt2);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_d_t();
    test_jk();
    test_sr_illegal();
    test_hold_priority();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
